// File: rtl/mux4_scan_ctrl_if.sv
// Handshake bundle between the scan sequencer and its user / downstream 4:1 mux.
// The master side drives control and receives frames; the slave side is the sequencer.
interface mux4_scan_ctrl_if #(
  parameter int DWELL_W = 4
);
  logic               start;
  logic               continuous;
  logic               abort;
  logic [DWELL_W-1:0] dwell;
  logic               mux_out;
  logic               sel0;
  logic               sel1;
  logic               busy;
  logic [3:0]         frame;
  logic               frame_valid;

  modport master (
    output start, continuous, abort, dwell, mux_out,
    input  sel0, sel1, busy, frame, frame_valid
  );

  modport slave (
    input  start, continuous, abort, dwell, mux_out,
    output sel0, sel1, busy, frame, frame_valid
  );
endinterface

// File: rtl/mux4_scan_ctrl.sv
// Drives the 4:1 mux selects through channels 0..3, samples mux_out after a
// programmable dwell and emits the assembled 4-bit frame with a one-cycle strobe.
module mux4_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux4_scan_ctrl_if.slave       bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state_q, state_d;
  logic [1:0]         ch_q, ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [3:0]         shadow_q, shadow_d;
  logic [3:0]         frame_q, frame_d;
  logic               frame_valid_q, frame_valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ch_q          <= 2'd0;
      cnt_q         <= '0;
      dwell_q       <= '0;
      shadow_q      <= 4'd0;
      frame_q       <= 4'd0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      cnt_q         <= cnt_d;
      dwell_q       <= dwell_d;
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    cnt_d         = cnt_q;
    dwell_d       = dwell_q;
    shadow_d      = shadow_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        ch_d = 2'd0;
        if (bus.start) begin
          state_d  = SCAN;
          cnt_d    = bus.dwell;
          dwell_d  = bus.dwell;
          shadow_d = 4'd0;
        end
      end
      SCAN: begin
        if (bus.abort) begin
          state_d = IDLE;
          ch_d    = 2'd0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          shadow_d[ch_q] = bus.mux_out;
          if (ch_q != 2'd3) begin
            ch_d  = ch_q + 2'd1;
            cnt_d = dwell_q;
          end else begin
            // Last channel: the just-sampled bit goes straight into the frame.
            frame_d       = shadow_d;
            frame_valid_d = 1'b1;
            ch_d          = 2'd0;
            if (bus.continuous) begin
              cnt_d    = bus.dwell;
              dwell_d  = bus.dwell;
              shadow_d = 4'd0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        ch_d    = 2'd0;
      end
    endcase
  end

  // The mux indexes data[2*sel0 + sel1], so sel0 carries the channel MSB.
  assign bus.sel0        = ch_q[1];
  assign bus.sel1        = ch_q[0];
  assign bus.busy        = (state_q == SCAN);
  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: models the downstream 4:1 mux and scoreboards
// expected frames and their arrival cycle against the DUT strobe.
module tb_mux4_scan_ctrl;

  localparam int DWELL_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] data = 4'd0;
  int cyc = 0;
  int errs = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] frame;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  mux4_scan_ctrl_if #(.DWELL_W(DWELL_W)) bus ();

  mux4_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mux_out = data[{bus.sel0, bus.sel1}];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic sel_is(input string tag, input logic [1:0] exp);
    chk(tag, {30'd0, bus.sel0, bus.sel1}, {30'd0, exp});
  endtask

  task automatic push(input logic [3:0] f, input int c);
    exp_t e;
    e.frame = f;
    e.cyc   = c;
    sb.push_back(e);
  endtask

  // Raise start, let one edge sample it, and return that edge number.
  task automatic start_scan(input logic [DWELL_W-1:0] d, input bit keep, output int e0);
    bus.dwell = d;
    bus.start = 1'b1;
    tick();
    e0 = cyc;
    if (!keep) bus.start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.frame_valid) begin
      if (sb.size() == 0) begin
        chk("fv_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("frame", {28'd0, bus.frame}, {28'd0, e.frame});
        chk("frame_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int e0;
    bus.start      = 1'b0;
    bus.continuous = 1'b0;
    bus.abort      = 1'b0;
    bus.dwell      = '0;

    // Reset state
    tick();
    chk("rst_busy", {31'd0, bus.busy}, 0);
    sel_is("rst_sel", 2'b00);
    chk("rst_frame", {28'd0, bus.frame}, 0);
    chk("rst_fv", {31'd0, bus.frame_valid}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset mid-scan
    data = 4'b1111;
    start_scan(4'd2, 1'b0, e0);
    chk("pre_rst_busy", {31'd0, bus.busy}, 1);
    wait_until(e0 + 5);
    sel_is("pre_rst_sel", 2'b01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 0);
    sel_is("mid_rst_sel", 2'b00);
    chk("mid_rst_frame", {28'd0, bus.frame}, 0);
    chk("mid_rst_fv", {31'd0, bus.frame_valid}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    data = 4'b0011;
    start_scan(4'd2, 1'b0, e0);
    push(4'b0011, e0 + 12);
    wait_until(e0 + 14);
    chk("after_rst_busy", {31'd0, bus.busy}, 0);

    // Single-shot, dwell 0
    data = 4'b1010;
    start_scan(4'd0, 1'b0, e0);
    push(4'b1010, e0 + 4);
    sel_is("ss_sel0", 2'b00);
    tick();
    sel_is("ss_sel1", 2'b01);
    tick();
    sel_is("ss_sel2", 2'b10);
    tick();
    sel_is("ss_sel3", 2'b11);
    tick();
    chk("ss_busy_end", {31'd0, bus.busy}, 0);
    sel_is("ss_sel_end", 2'b00);
    tick();
    chk("ss_fv_one_cycle", {31'd0, bus.frame_valid}, 0);

    // Dwell 3 with a mid-frame dwell change
    data = 4'b0110;
    start_scan(4'd3, 1'b0, e0);
    push(4'b0110, e0 + 16);
    tick();
    bus.dwell = 4'd0;
    wait_until(e0 + 3);
    sel_is("dw_hold_ch0", 2'b00);
    tick();
    sel_is("dw_ch1", 2'b01);
    wait_until(e0 + 11);
    sel_is("dw_hold_ch2", 2'b10);
    wait_until(e0 + 15);
    chk("dw_busy", {31'd0, bus.busy}, 1);
    wait_until(e0 + 17);
    chk("dw_busy_end", {31'd0, bus.busy}, 0);

    // Continuous, dwell 1
    data = 4'b1111;
    bus.continuous = 1'b1;
    start_scan(4'd1, 1'b0, e0);
    push(4'b1111, e0 + 8);
    push(4'b0001, e0 + 16);
    push(4'b0101, e0 + 24);
    wait_until(e0 + 8);
    data = 4'b0001;
    chk("cont_no_gap", {31'd0, bus.busy}, 1);
    sel_is("cont_restart_ch0", 2'b00);
    wait_until(e0 + 16);
    data = 4'b0101;
    chk("cont_busy2", {31'd0, bus.busy}, 1);
    wait_until(e0 + 18);
    bus.continuous = 1'b0;
    wait_until(e0 + 23);
    chk("cont_busy_last", {31'd0, bus.busy}, 1);
    tick();
    chk("cont_busy_end", {31'd0, bus.busy}, 0);
    tick();

    // Abort at channel 2 with start held high throughout
    data = 4'b0000;
    start_scan(4'd0, 1'b1, e0);
    tick();
    sel_is("ab_start_ignored", 2'b01);
    tick();
    sel_is("ab_ch2", 2'b10);
    bus.abort = 1'b1;
    bus.start = 1'b0;
    tick();
    bus.abort = 1'b0;
    chk("ab_busy", {31'd0, bus.busy}, 0);
    sel_is("ab_sel", 2'b00);
    chk("ab_frame_kept", {28'd0, bus.frame}, {28'd0, 4'b0101});
    chk("ab_fv", {31'd0, bus.frame_valid}, 0);
    repeat (6) tick();
    chk("ab_stays_idle", {31'd0, bus.busy}, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
